mask_rd_arbiter: RTL and testbench
==================================

// Module: mask_rd_arbiter
// PURPOSE
//  Shares read port B of the 640x480x1 foreground-mask frame memory between two requesters:
//  - the video display path: hard real-time, no handshake, always wins.
//  - the blob statistics engine: burst reads, valid/ready handshake, served only in idle cycles.
//  Sits between the display timing (vid_hpos/vid_vpos) and frame_mem port B; a response-tag pipeline
//  routes each returned bit to its owner.
// PARAMETERS
//  H_RES    640  active pixels per line
//  V_RES    480  active lines per frame
//  AW       19   frame address width (H_RES*V_RES <= 2**AW)
//  RAM_LAT  1    frame_mem read latency, cycles (1..3)
// PORTS
//  app_clk      in   1    single clock (video/app clock)
//  app_rst_n    in   1    synchronous reset, active-low
//  vid_hpos     in   11   display horizontal position
//  vid_vpos     in   11   display vertical position
//  disp_px      out  1    mask bit for display, registered
//  req_valid    in   1    analyzer burst request
//  req_ready    out  1    arbiter accepts request this cycle
//  req_addr     in   AW   burst start address (hpos + H_RES*vpos)
//  req_len      in   10   burst length in pixels, 0..640
//  rsp_valid    out  1    analyzer read data valid
//  rsp_data     out  1    analyzer read data bit
//  rsp_last     out  1    with rsp_valid: final beat of burst
//  burst_done   out  1    1-cycle pulse: burst fully returned (also for len 0)
//  ram_addrb    out  AW   frame_mem port B address
//  ram_doutb    in   1    frame_mem port B data, RAM_LAT after ram_addrb
// BEHAVIOUR
//  Reset (app_rst_n=0 at clock edge): state=IDLE.
//   - disp_px, rsp_valid, rsp_data, rsp_last, burst_done = 0; req_ready = 0; ram_addrb = 0.
//   - tag pipeline cleared; in-flight data dropped.
//   - Reset mid-burst produces no rsp_valid/burst_done for that burst.
//  disp_need = (vid_hpos < H_RES) && (vid_vpos < V_RES). When 1, ram_addrb = vid_hpos + H_RES*vid_vpos
//   (combinational), tag = DISP.
//  Tag pipeline: RAM_LAT+1 stages of {owner, last}; owner in {NONE, DISP, ANA}.
//  Outputs at tail of pipeline:
//   - DISP: disp_px <= ram_doutb.
//   - ANA : rsp_valid<=1, rsp_data<=ram_doutb, rsp_last<=last.
//   - NONE: disp_px<=0, rsp_valid<=0.
//   Total latency address->output = RAM_LAT+1 cycles for both owners.
//  FSM:
//   - IDLE: req_ready=1. On req_valid: latch addr/len.
//     - len=0 -> DONE0.
//     - else -> ISSUE.
//   - ISSUE: req_ready=0. Each cycle with !disp_need:
//     - ram_addrb=cur_addr, tag=ANA, cur_addr++, rem--.
//     - cur_addr wraps H_RES*V_RES-1 -> 0.
//     - Beat with rem==1 carries last=1 -> DRAIN.
//     - Cycles with disp_need issue nothing (stall, no timeout).
//   - DRAIN: wait until last-tagged beat leaves pipeline (rsp_last); burst_done pulses the same
//     cycle as rsp_last -> IDLE.
//   - DONE0: burst_done=1 for one cycle, no rsp beats -> IDLE.
//  Request accepted while disp_need=1: accepted normally; first beat waits for first idle cycle.
//  Unselected cycles (IDLE, no display): ram_addrb holds last value, tag=NONE.
//  req_ready is a registered function of state; back-to-back bursts need >=1 IDLE cycle between them.
// TESTING
//  T1 reset: app_rst_n=0 for 3 clks during burst -> all outputs 0, no rsp_valid/burst_done afterwards.
//  T2 display only: hpos 0..639, vpos=5, RAM preloaded addr parity -> disp_px equals mem[3200+h]
//     exactly RAM_LAT+1 cycles later; hpos=700 -> disp_px=0.
//  T3 blanking burst: vpos=490, req addr=1000 len=4 -> 4 rsp_valid beats = mem[1000..1003] on
//     consecutive cycles, rsp_last and burst_done on beat 4.
//  T4 preemption: len=8 issued starting at hpos=636, vpos=479->480 transition -> beats resume
//     only after display idle, data in order, no dropped or duplicate beats.
//  T5 wrap: addr=307198 len=3 -> beats mem[307198], mem[307199], mem[0].
//  T6 len=0: accept -> burst_done 1-cycle pulse, zero rsp_valid, req_ready high the cycle after.

Source files
------------

// File: rtl/mask_rd_arbiter.sv
// Arbitrates frame_mem port B between the hard real-time display scan and the
// blob-statistics burst reader; a tag pipeline steers each returned bit to its owner.
module mask_rd_arbiter #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int AW      = 19,
    parameter int RAM_LAT = 1
) (
    input  logic          app_clk,
    input  logic          app_rst_n,
    input  logic [10:0]   vid_hpos,
    input  logic [10:0]   vid_vpos,
    output logic          disp_px,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [9:0]    req_len,
    output logic          rsp_valid,
    output logic          rsp_data,
    output logic          rsp_last,
    output logic          burst_done,
    output logic [AW-1:0] ram_addrb,
    input  logic          ram_doutb
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE0} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_ANA} owner_e;
    typedef struct packed {
        owner_e owner;
        logic   last;
    } tag_t;

    localparam tag_t          TAG_NONE   = '{owner: OWN_NONE, last: 1'b0};
    localparam logic [AW-1:0] FRAME_LAST = AW'(H_RES * V_RES - 1);

    state_e        state, state_nxt;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] addr_hold;
    logic [9:0]    rem;
    logic          disp_need;
    logic          ana_issue;
    logic          accept;
    logic          ana_done;
    logic [AW-1:0] disp_addr;
    tag_t          tag_head;
    tag_t          tag_tail;
    tag_t          tag_pipe [RAM_LAT:1];

    assign disp_need = (vid_hpos < 11'(H_RES)) && (vid_vpos < 11'(V_RES));
    assign disp_addr = AW'(vid_hpos) + AW'(H_RES) * AW'(vid_vpos);
    assign ana_issue = (state == ST_ISSUE) && !disp_need;
    assign accept    = (state == ST_IDLE) && req_valid && req_ready;
    assign tag_tail  = tag_pipe[RAM_LAT];
    assign ana_done  = (tag_tail.owner == OWN_ANA) && tag_tail.last;

    // Display always owns the port; analyzer beats only fill cycles the scan leaves idle.
    always_comb begin
        ram_addrb = addr_hold;
        tag_head  = TAG_NONE;
        if (disp_need) begin
            ram_addrb      = disp_addr;
            tag_head.owner = OWN_DISP;
        end else if (ana_issue) begin
            ram_addrb      = cur_addr;
            tag_head.owner = OWN_ANA;
            tag_head.last  = (rem == 10'd1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = (req_len == 10'd0) ? ST_DONE0 : ST_ISSUE;
            ST_ISSUE: if (ana_issue && rem == 10'd1) state_nxt = ST_DRAIN;
            ST_DRAIN: if (ana_done) state_nxt = ST_IDLE;
            ST_DONE0: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge app_clk) begin
        if (!app_rst_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            cur_addr  <= '0;
            rem       <= '0;
            addr_hold <= '0;
        end else begin
            state     <= state_nxt;
            req_ready <= (state_nxt == ST_IDLE);
            addr_hold <= ram_addrb;
            if (accept) begin
                cur_addr <= req_addr;
                rem      <= req_len;
            end else if (ana_issue) begin
                cur_addr <= (cur_addr == FRAME_LAST) ? '0 : cur_addr + AW'(1);
                rem      <= rem - 10'd1;
            end
        end
    end

    // Tag stage k describes the read whose data appears on ram_doutb k cycles after issue.
    always_ff @(posedge app_clk) begin
        if (!app_rst_n) begin
            for (int i = 1; i <= RAM_LAT; i++) tag_pipe[i] <= TAG_NONE;
        end else begin
            tag_pipe[1] <= tag_head;
            for (int i = 2; i <= RAM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_ff @(posedge app_clk) begin
        if (!app_rst_n) begin
            disp_px    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 1'b0;
            rsp_last   <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            disp_px    <= (tag_tail.owner == OWN_DISP) ? ram_doutb : 1'b0;
            rsp_valid  <= (tag_tail.owner == OWN_ANA);
            rsp_data   <= (tag_tail.owner == OWN_ANA) ? ram_doutb : 1'b0;
            rsp_last   <= ana_done;
            burst_done <= ana_done || (state == ST_DONE0);
        end
    end

endmodule

// File: tb/tb_mask_rd_arbiter.sv
// Directed bench for mask_rd_arbiter: frame memory model, per-cycle behavioural
// reference of both read streams, plus literal spot checks.
module tb_mask_rd_arbiter;

    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int AW    = 19;
    localparam int L     = 1;
    localparam int FRAME = H_RES * V_RES;

    logic          app_clk = 1'b0;
    logic          app_rst_n;
    logic [10:0]   vid_hpos, vid_vpos;
    logic          disp_px;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr;
    logic [9:0]    req_len;
    logic          rsp_valid, rsp_data, rsp_last, burst_done;
    logic [AW-1:0] ram_addrb;
    logic          ram_doutb;

    mask_rd_arbiter #(.H_RES(H_RES), .V_RES(V_RES), .AW(AW), .RAM_LAT(L)) dut (
        .app_clk(app_clk), .app_rst_n(app_rst_n),
        .vid_hpos(vid_hpos), .vid_vpos(vid_vpos), .disp_px(disp_px),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .burst_done(burst_done),
        .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
    );

    always #5 app_clk = ~app_clk;

    // Mask content: bit parity of the address.
    function automatic logic mem_bit(input int a);
        logic [AW-1:0] v;
        v = AW'(a);
        return ^v;
    endfunction

    logic ram_pipe [L];
    always @(posedge app_clk) begin
        ram_pipe[0] <= mem_bit(int'(ram_addrb));
        for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign ram_doutb = ram_pipe[L-1];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: each cycle's read is either a display pixel, the next pending
    // analyzer beat, or nothing; its result shows up L+1 cycles later.
    typedef struct { bit disp; bit ana; bit data; bit last; } ent_t;
    typedef struct { int addr; bit last; } beat_t;

    ent_t  hq[$];
    beat_t pend[$];
    int    ecount = 0;
    int    done0_edge = -1;
    bit    m_busy = 0, m_ready = 0;
    bit    e_disp, e_rv, e_rd, e_rl, e_bd;

    always @(posedge app_clk) begin : model
        ent_t  e, t;
        beat_t b;
        bit    need;
        int    h, v;
        ecount++;
        h    = int'(vid_hpos);
        v    = int'(vid_vpos);
        need = (h < H_RES) && (v < V_RES);
        e    = '{default: 0};
        if (!app_rst_n) begin
            pend.delete();
            m_busy     = 0;
            done0_edge = -1;
        end else begin
            if (need) begin
                e.disp = 1;
                e.data = mem_bit(h + H_RES * v);
            end else if (pend.size() > 0) begin
                b = pend.pop_front();
                e.ana  = 1;
                e.data = mem_bit(b.addr);
                e.last = b.last;
            end
            if (req_valid && m_ready) begin
                m_busy = 1;
                if (req_len == 10'd0) done0_edge = ecount + 1;
                else for (int i = 0; i < int'(req_len); i++) begin
                    b.addr = (int'(req_addr) + i) % FRAME;
                    b.last = (i == int'(req_len) - 1);
                    pend.push_back(b);
                end
            end
        end
        hq.push_back(e);
        if (hq.size() > L + 1) hq.delete(0);
        if (!app_rst_n) foreach (hq[i]) hq[i] = '{default: 0};
        t = (hq.size() == L + 1) ? hq[0] : '{default: 0};
        e_disp = t.disp && t.data;
        e_rv   = t.ana;
        e_rd   = t.ana && t.data;
        e_rl   = t.ana && t.last;
        e_bd   = e_rl || (app_rst_n && ecount == done0_edge);
        if (e_bd) m_busy = 0;
        m_ready = app_rst_n && !m_busy;
    end

    logic cap[$];
    int   bd_cnt = 0;

    always @(negedge app_clk) begin
        if (ecount >= 1) begin
            check("disp_px", int'(disp_px), int'(e_disp));
            check("rsp_valid", int'(rsp_valid), int'(e_rv));
            if (e_rv) check("rsp_data", int'(rsp_data), int'(e_rd));
            check("rsp_last", int'(rsp_last), int'(e_rl));
            check("burst_done", int'(burst_done), int'(e_bd));
            check("req_ready", int'(req_ready), int'(m_ready));
            if (vid_hpos < 11'(H_RES) && vid_vpos < 11'(V_RES))
                check("ram_addrb", int'(ram_addrb), int'(vid_hpos) + H_RES * int'(vid_vpos));
            if (rsp_valid) cap.push_back(rsp_data);
            if (burst_done) bd_cnt++;
        end
    end

    task automatic tick();
        @(posedge app_clk);
        #1;
    endtask

    task automatic set_pos(input int h, input int v);
        vid_hpos = 11'(h);
        vid_vpos = 11'(v);
    endtask

    task automatic request(input int a, input int n);
        req_addr  = AW'(a);
        req_len   = 10'(n);
        req_valid = 1'b1;
        for (int k = 0; k < 200 && !req_ready; k++) tick();
        check("req_accept_wait", int'(req_ready), 1);
        if (req_ready) tick();
        req_valid = 1'b0;
    endtask

    task automatic check_cap(input string nm, input int exp_len, input logic [7:0] exp_bits);
        logic [7:0] bits;
        bits = exp_bits;
        check({nm, "_beats"}, cap.size(), exp_len);
        for (int i = 0; i < exp_len && i < cap.size(); i++)
            check({nm, "_bit"}, int'(cap[i]), int'(bits[i]));
    endtask

    initial begin
        app_rst_n = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        set_pos(700, 490);
        repeat (3) tick();
        app_rst_n = 1'b1;
        tick();
        check("ready_after_reset", int'(req_ready), 1);

        // T1: reset for 3 clocks in the middle of a burst
        request(2000, 20);
        repeat (4) tick();
        app_rst_n = 1'b0;
        repeat (3) tick();
        check("t1_rst_rsp_valid", int'(rsp_valid), 0);
        check("t1_rst_burst_done", int'(burst_done), 0);
        check("t1_rst_req_ready", int'(req_ready), 0);
        check("t1_rst_ram_addrb", int'(ram_addrb), 0);
        app_rst_n = 1'b1;
        cap.delete();
        bd_cnt = 0;
        repeat (30) tick();
        check("t1_no_beats", cap.size(), 0);
        check("t1_no_done", bd_cnt, 0);

        // T2: display scan on line 5, then horizontal blanking
        for (int h = 0; h < H_RES; h++) begin
            set_pos(h, 5);
            tick();
        end
        set_pos(3, 5);
        repeat (L + 2) tick();
        check("t2_px_3203", int'(disp_px), 1);
        set_pos(2, 5);
        repeat (L + 2) tick();
        check("t2_px_3202", int'(disp_px), 0);
        set_pos(700, 5);
        repeat (L + 2) tick();
        check("t2_px_blank", int'(disp_px), 0);

        // T3: burst entirely in vertical blanking
        set_pos(700, 490);
        cap.delete();
        bd_cnt = 0;
        request(1000, 4);
        repeat (10) tick();
        check_cap("t3", 4, 8'b0000_0110);
        check("t3_done", bd_cnt, 1);

        // T4: burst accepted during display, interrupted by the next line
        set_pos(636, 478);
        cap.delete();
        bd_cnt = 0;
        request(5000, 8);
        for (int h = 637; h < 646; h++) begin
            set_pos(h, 478);
            tick();
        end
        for (int h = 0; h < 4; h++) begin
            set_pos(h, 479);
            tick();
        end
        for (int h = 4; h < 20; h++) begin
            set_pos(h, 480);
            tick();
        end
        check("t4_beats", cap.size(), 8);
        for (int i = 0; i < 8 && i < cap.size(); i++)
            check("t4_bit", int'(cap[i]), int'(mem_bit(5000 + i)));
        check("t4_done", bd_cnt, 1);

        // T5: address wrap at the end of the frame
        set_pos(700, 490);
        cap.delete();
        bd_cnt = 0;
        request(307198, 3);
        repeat (10) tick();
        check_cap("t5", 3, 8'b0000_0010);
        check("t5_done", bd_cnt, 1);

        // T6: zero-length burst
        cap.delete();
        bd_cnt = 0;
        request(123, 0);
        tick();
        check("t6_done_pulse", int'(burst_done), 1);
        tick();
        check("t6_done_low", int'(burst_done), 0);
        check("t6_ready", int'(req_ready), 1);
        repeat (5) tick();
        check("t6_done_cnt", bd_cnt, 1);
        check("t6_no_beats", cap.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
